// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family: FSM state encoding and
// the default parallel word width.
package shift_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int SHIFT_REG_WIDTH = 8;

endpackage

// File: rtl/shift_reg_piso_ser.sv
// PISO serializer: accepts a parallel word over valid/ready and shifts it
// out one bit per clock with frame-valid, busy and last-bit done qualifiers.
module shift_reg_piso_ser
    import shift_reg_pkg::*;
#(
    parameter int   WIDTH      = SHIFT_REG_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             last_bit;

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);

    // Handshake: a word transfers on a rising edge where load_valid && load_ready.
    // load_ready comes only from registers, so the source may hold load_valid
    // and d until it sees ready; nothing is captured on any other edge.
    assign load_ready = (state == ST_IDLE) || last_bit;

    assign sout_valid = (state == ST_SHIFT);
    assign busy       = (state == ST_SHIFT);
    assign done       = last_bit;
    assign sout       = (state == ST_SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                            : IDLE_LEVEL;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (MSB_FIRST) begin
                    shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
                end
                if (last_bit) begin
                    // Counter parks at zero so non-power-of-two widths never overrun.
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A new word overrides the idle return, giving gap-free back-to-back frames.
        if (load_valid && load_ready) begin
            shreg_nxt   = d;
            bit_cnt_nxt = '0;
            state_nxt   = ST_SHIFT;
        end
    end

endmodule

// File: tb/tb_shift_reg_piso_ser.sv
// Randomized and directed bench for shift_reg_piso_ser (MSB- and LSB-first
// instances) against a queue-of-pending-bits reference model.
module tb_shift_reg_piso_ser;
    import shift_reg_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [W-1:0] d_m, d_l;
    logic         lv_m, lv_l;
    logic         lr_m, so_m, sv_m, busy_m, done_m;
    logic         lr_l, so_l, sv_l, busy_l, done_l;
    state_t       st_m, st_l;

    shift_reg_piso_ser #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d_m),
        .load_valid (lv_m),
        .load_ready (lr_m),
        .sout       (so_m),
        .sout_valid (sv_m),
        .busy       (busy_m),
        .done       (done_m),
        .state_dbg  (st_m)
    );

    shift_reg_piso_ser #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d_l),
        .load_valid (lv_l),
        .load_ready (lr_l),
        .sout       (so_l),
        .sout_valid (sv_l),
        .busy       (busy_l),
        .done       (done_l),
        .state_dbg  (st_l)
    );

    // ---------------- scoreboard / model ----------------
    // Each queue holds the bits still to appear on sout, front = current bit.
    logic [0:0]  exp_q_m[$];
    logic [0:0]  exp_q_l[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          accepts_m = 0;
    int          accepts_l = 0;
    int          done_cnt_m = 0;
    int          done_cnt_l = 0;
    logic [31:0] cap_m = '0;
    logic [31:0] cap_l = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic has_m, has_l;
        has_m = (exp_q_m.size() > 0);
        has_l = (exp_q_l.size() > 0);
        check_val("m_valid", 32'(sv_m),   32'(has_m));
        check_val("m_busy",  32'(busy_m), 32'(has_m));
        check_val("m_state", 32'(st_m),   32'(has_m ? ST_SHIFT : ST_IDLE));
        check_val("m_ready", 32'(lr_m),   32'(exp_q_m.size() <= 1));
        check_val("m_done",  32'(done_m), 32'(exp_q_m.size() == 1));
        check_val("m_sout",  32'(so_m),   32'(has_m ? exp_q_m[0] : 1'b1));
        check_val("l_valid", 32'(sv_l),   32'(has_l));
        check_val("l_busy",  32'(busy_l), 32'(has_l));
        check_val("l_state", 32'(st_l),   32'(has_l ? ST_SHIFT : ST_IDLE));
        check_val("l_ready", 32'(lr_l),   32'(exp_q_l.size() <= 1));
        check_val("l_done",  32'(done_l), 32'(exp_q_l.size() == 1));
        check_val("l_sout",  32'(so_l),   32'(has_l ? exp_q_l[0] : 1'b1));
        if (sv_m) cap_m = {cap_m[30:0], so_m};
        if (sv_l) cap_l = {so_l, cap_l[31:1]};
        if (done_m) done_cnt_m++;
        if (done_l) done_cnt_l++;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        logic rdy_m, rdy_l;
        rdy_m = (exp_q_m.size() <= 1);
        rdy_l = (exp_q_l.size() <= 1);
        if (exp_q_m.size() > 0) void'(exp_q_m.pop_front());
        if (exp_q_l.size() > 0) void'(exp_q_l.pop_front());
        if (lv_m && rdy_m) begin
            accepts_m++;
            for (int i = W - 1; i >= 0; i--) exp_q_m.push_back(d_m[i]);
        end
        if (lv_l && rdy_l) begin
            accepts_l++;
            for (int i = 0; i < W; i++) exp_q_l.push_back(d_l[i]);
        end
    endtask

    // Called at a falling edge: check, advance one clock, return at next falling edge.
    task automatic cycle();
        check_outputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lv_m = 1'b0;
        lv_l = 1'b0;
    endtask

    task automatic run_idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        d_m = '0; d_l = '0; lv_m = 1'b0; lv_l = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: idle after reset
        run_idle(5);

        // 2: MSB-first A5
        cap_m = '0; done_cnt_m = 0;
        d_m = 8'hA5; lv_m = 1'b1;
        cycle();
        lv_m = 1'b0; d_m = 8'h00;
        run_idle(9);
        check_val("a5_stream", cap_m & 32'hFF, 32'hA5);
        check_val("a5_done_cnt", 32'(done_cnt_m), 32'd1);

        // 3: back-to-back 24 then 09 with load_valid held
        cap_m = '0; done_cnt_m = 0; accepts_m = 0;
        d_m = 8'h24; lv_m = 1'b1;
        for (int i = 0; i < 20 && accepts_m < 2; i++) begin
            cycle();
            if (accepts_m == 1) d_m = 8'h09;
        end
        check_val("b2b_accepts", 32'(accepts_m), 32'd2);
        run_idle(10);
        check_val("b2b_stream", cap_m & 32'hFFFF, 32'h2409);
        check_val("b2b_done_cnt", 32'(done_cnt_m), 32'd2);

        // 4: LSB-first 0D
        cap_l = '0; done_cnt_l = 0;
        d_l = 8'h0D; lv_l = 1'b1;
        cycle();
        lv_l = 1'b0; d_l = 8'h55;
        run_idle(9);
        check_val("0d_stream", cap_l >> 24, 32'h0D);
        check_val("0d_done_cnt", 32'(done_cnt_l), 32'd1);

        // 5: ED with ignored FF pulse at bit 3
        cap_m = '0;
        d_m = 8'hED; lv_m = 1'b1;
        cycle();
        lv_m = 1'b0;
        run_idle(3);
        check_val("mid_ready_low", 32'(lr_m), 32'd0);
        d_m = 8'hFF; lv_m = 1'b1;
        cycle();
        lv_m = 1'b0;
        run_idle(8);
        check_val("ed_stream", cap_m & 32'hFF, 32'hED);

        // 6: async reset after 4 bits of F9, then clean 65
        done_cnt_m = 0;
        d_m = 8'hF9; lv_m = 1'b1;
        cycle();
        lv_m = 1'b0;
        run_idle(3);
        check_outputs();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_valid", 32'(sv_m), 32'd0);
        check_val("rst_sout",  32'(so_m), 32'd1);
        check_val("rst_done",  32'(done_m), 32'd0);
        check_val("rst_ready", 32'(lr_m), 32'd1);
        check_val("rst_busy",  32'(busy_m), 32'd0);
        exp_q_m.delete();
        exp_q_l.delete();
        @(negedge clk);
        reset_n = 1'b1;
        check_val("rst_no_done", 32'(done_cnt_m), 32'd0);
        cap_m = '0;
        d_m = 8'h65; lv_m = 1'b1;
        cycle();
        lv_m = 1'b0;
        run_idle(9);
        check_val("65_stream", cap_m & 32'hFF, 32'h65);

        // Random phase: random valid and data on both instances
        for (int i = 0; i < 400; i++) begin
            lv_m = ($urandom_range(0, 3) != 0);
            lv_l = ($urandom_range(0, 2) == 0);
            d_m  = W'($urandom);
            d_l  = W'($urandom);
            cycle();
        end
        run_idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global timeout guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/shift_reg_piso_ser.md
Name: shift_reg_piso_ser

Overview:
Parallel-in serial-out serializer that sits directly downstream of the 8-bit PIPO register stage. It takes the registered parallel byte (PIPO q) through a valid/ready handshake and shifts it out one bit per clock with a frame-valid qualifier. It emits a done pulse on the last bit and supports back-to-back words with no idle gap.

Parameters:
WIDTH, 8, parallel word width in bits; legal range WIDTH >= 2
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
IDLE_LEVEL, 1'b1, value driven on sout whenever sout_valid = 0

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset
d  input  WIDTH  parallel word, normally driven by PIPO q
load_valid  input  1  source has a word on d
load_ready  output  1  serializer accepts d this cycle
sout  output  1  serial data bit
sout_valid  output  1  sout carries a frame bit this cycle
busy  output  1  frame in progress (state = SHIFT)
done  output  1  one-cycle pulse, high while the last bit of a frame is on sout

Behaviour:
- States: IDLE and SHIFT. Internal registers: shreg[WIDTH-1:0] and bit_cnt[$clog2(WIDTH)-1:0].
- Reset (async, takes effect immediately while reset_n = 0):
  - state = IDLE, shreg = 0, bit_cnt = 0.
  - sout = IDLE_LEVEL, sout_valid = 0, busy = 0, done = 0, load_ready = 1.
- load_ready = (state == IDLE) || (state == SHIFT && bit_cnt == WIDTH-1). It depends only on registers and never on load_valid.
- Accept: on a rising edge with load_valid && load_ready:
  - shreg <= d, bit_cnt <= 0, state <= SHIFT.
  - d is sampled only at this edge. Later changes on d have no effect.
- SHIFT:
  - sout = shreg[WIDTH-1] when MSB_FIRST = 1, shreg[0] when MSB_FIRST = 0.
  - sout_valid = 1, busy = 1.
  - Each edge: shreg shifts toward the output end, 0 fills the vacated bit, bit_cnt increments.
- Last bit (bit_cnt == WIDTH-1): done = 1 in that cycle. On the next edge:
  - If load_valid is high, the new word is accepted. State stays SHIFT, bit_cnt = 0, no gap cycle.
  - Otherwise state returns to IDLE.
- Latency: word accepted at edge k; bit 0 of the frame appears after edge k, the last bit after edge k+WIDTH-1. A frame is exactly WIDTH contiguous valid cycles.
- IDLE: sout = IDLE_LEVEL, sout_valid = 0, busy = 0, done = 0.
- load_valid while in SHIFT with bit_cnt < WIDTH-1: ignored, no capture. The source must hold the word until load_ready.
- Reset mid-frame: the frame is aborted immediately. No done is emitted, and the partial word is discarded.
- Outputs sout, sout_valid, busy and done are derived only from registers. There is no combinational path from d or load_valid to any output.

Decomposition:
- Shared package shift_reg_pkg holds:
  - state encodings ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
  - default width constant SHIFT_REG_WIDTH = 8.
- The counter width is computed locally from WIDTH.
- Single module; no sub-module is warranted. The counter and shifter are trivial.

Test Plan:
1. Idle after reset, no load_valid for 5 cycles -> sout = 1, sout_valid = 0, busy = 0, load_ready = 1 throughout.
2. MSB_FIRST = 1, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 over 8 consecutive cycles with sout_valid = 1; done high only on the 8th cycle; then IDLE.
3. Back-to-back: load_valid held with 8'h24 then 8'h09 -> 16 contiguous sout_valid cycles (0,0,1,0,0,1,0,0,0,0,0,0,1,0,0,1). load_ready is high only in IDLE before the first word and on each last-bit cycle. done pulses twice.
4. MSB_FIRST = 0 instance, load 8'h0D -> sout = 1,0,1,1,0,0,0,0; done on the 8th bit.
5. During the frame for 8'hED, pulse load_valid with d = 8'hFF at bit 3 -> ignored; stream stays 1,1,1,0,1,1,0,1 and load_ready = 0 at that cycle.
6. Assert reset_n = 0 mid-cycle after 4 bits of 8'hF9 -> sout_valid drops to 0 immediately (before the next edge), sout = 1, no done. After release, load 8'h65 -> clean 0,1,1,0,0,1,0,1.
